// File: rtl/bram_readback_checker.sv
// rtl/bram_readback_checker.sv - scans a BRAM and checks every word against its address pattern (A*2)
// Optional feature macro: BRAM_CHK_FIRST_ERR_CAPTURE_EN adds first-mismatch capture outputs.
module bram_readback_checker #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk_30mhz,
    input  logic              reset,
    input  logic              locked,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              abort,
`ifdef BRAM_CHK_FIRST_ERR_CAPTURE_EN
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [0:0]        first_err_vld,
`endif
    output logic [15:0]       err_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t            state;
    logic [1:0]        drain_cnt;
    logic [RD_LAT-1:0] pipe_vld;
    logic [ADDR_W-1:0] pipe_addr [RD_LAT];

    logic              al_vld;
    logic [ADDR_W-1:0] al_addr;
    logic [DATA_W-1:0] exp_word;
    logic              mismatch;
    logic [15:0]       err_next;
    logic              lock_lost;
    logic              start_ok;

    // Aligned compare against the address pattern, saturating error increment, FSM qualifiers
    always_comb begin
        al_vld   = pipe_vld[RD_LAT-1];
        al_addr  = pipe_addr[RD_LAT-1];
        exp_word = '0;
        exp_word[ADDR_W:0] = {al_addr, 1'b0};
        mismatch = al_vld && (rd_data != exp_word);
        err_next = err_count;
        if (mismatch && (err_count != 16'hFFFF)) begin
            err_next = err_count + 16'd1;
        end
        lock_lost = ((state == SCAN) || (state == DRAIN)) && !locked;
        start_ok  = ((state == IDLE) || (state == DONE)) && start && locked;
    end

    // Valid/address shift pipeline matching the BRAM read latency; valids flush on reset or lock loss
    always_ff @(posedge clk_30mhz) begin
        pipe_addr[0] <= rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
        end
        if (reset || lock_lost) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    // Scan FSM with registered outputs and error accounting
    always_ff @(posedge clk_30mhz) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= 2'd0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            abort     <= 1'b0;
            err_count <= 16'd0;
`ifdef BRAM_CHK_FIRST_ERR_CAPTURE_EN
            first_err_addr <= '0;
            first_err_data <= '0;
            first_err_vld  <= 1'b0;
`endif
        end else begin
            abort <= 1'b0;
            // Compares land whenever the scan is not being cancelled; a new start overrides below
            if (!lock_lost) begin
                err_count <= err_next;
`ifdef BRAM_CHK_FIRST_ERR_CAPTURE_EN
                if (mismatch && !first_err_vld[0]) begin
                    first_err_vld  <= 1'b1;
                    first_err_addr <= al_addr;
                    first_err_data <= rd_data;
                end
`endif
            end
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state     <= SCAN;
                        rd_en     <= 1'b1;
                        rd_addr   <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= 16'd0;
`ifdef BRAM_CHK_FIRST_ERR_CAPTURE_EN
                        first_err_addr <= '0;
                        first_err_data <= '0;
                        first_err_vld  <= 1'b0;
`endif
                    end
                end
                SCAN, DRAIN: begin
                    if (!locked) begin
                        state   <= IDLE;
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        abort   <= 1'b1;
                    end else if (state == SCAN) begin
                        if (rd_addr == '1) begin
                            state     <= DRAIN;
                            rd_en     <= 1'b0;
                            rd_addr   <= '0;
                            drain_cnt <= 2'd0;
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end else if (drain_cnt == 2'(RD_LAT - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 16'd0);
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_readback_checker.sv
// tb/tb_bram_readback_checker.sv - directed/randomized bench for bram_readback_checker at two latencies
module tb_bram_readback_checker;

    logic        clk_30mhz = 1'b0;
    logic        reset = 1'b1;
    logic        locked = 1'b1;
    logic        start = 1'b0;

    logic        rd_en1, busy1, done1, pass1, abort1;
    logic [3:0]  rd_addr1;
    logic [31:0] rd_data1;
    logic [15:0] err1;

    logic        rd_en2, busy2, done2, pass2, abort2;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data2, p0, p1;
    logic [15:0] err2;

`ifdef BRAM_CHK_FIRST_ERR_CAPTURE_EN
    logic [3:0]  fe_addr1;
    logic [31:0] fe_data1;
    logic [0:0]  fe_vld1;
    logic [4:0]  fe_addr2;
    logic [31:0] fe_data2;
    logic [0:0]  fe_vld2;
`endif

    logic [31:0] mem [32];
    int vectors = 0;
    int miscompares = 0;

    always #17 clk_30mhz = ~clk_30mhz;

    bram_readback_checker #(.ADDR_W(4), .DATA_W(32), .RD_LAT(1)) u_dut1 (
        .clk_30mhz(clk_30mhz), .reset(reset), .locked(locked), .start(start),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .busy(busy1), .done(done1), .pass(pass1), .abort(abort1),
`ifdef BRAM_CHK_FIRST_ERR_CAPTURE_EN
        .first_err_addr(fe_addr1), .first_err_data(fe_data1), .first_err_vld(fe_vld1),
`endif
        .err_count(err1)
    );

    bram_readback_checker #(.ADDR_W(5), .DATA_W(32), .RD_LAT(3)) u_dut2 (
        .clk_30mhz(clk_30mhz), .reset(reset), .locked(locked), .start(start),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .busy(busy2), .done(done2), .pass(pass2), .abort(abort2),
`ifdef BRAM_CHK_FIRST_ERR_CAPTURE_EN
        .first_err_addr(fe_addr2), .first_err_data(fe_data2), .first_err_vld(fe_vld2),
`endif
        .err_count(err2)
    );

    // BRAM models: data appears RD_LAT cycles after an enabled address, garbage otherwise
    always @(posedge clk_30mhz) begin
        rd_data1 <= rd_en1 ? mem[rd_addr1] : $urandom;
        p0       <= rd_en2 ? mem[rd_addr2] : $urandom;
        p1       <= p0;
        rd_data2 <= p1;
    end

    task automatic tick();
        @(posedge clk_30mhz);
        @(negedge clk_30mhz);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_errs(input int depth);
        int c = 0;
        for (int a = 0; a < depth; a++) if (mem[a] !== 32'(a * 2)) c++;
        return (c > 65535) ? 65535 : c;
    endfunction

    function automatic int ref_first(input int depth);
        for (int a = 0; a < depth; a++) if (mem[a] !== 32'(a * 2)) return a;
        return 0;
    endfunction

    task automatic fill_mem(input int pct);
        logic [31:0] v;
        for (int a = 0; a < 32; a++) begin
            if ($urandom_range(99) < pct) begin
                v = $urandom;
                if (v == 32'(a * 2)) v = v ^ 32'd1;
                mem[a] = v;
            end else begin
                mem[a] = 32'(a * 2);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd_en1"}, rd_en1, 0);   check({tag, "_rd_addr1"}, rd_addr1, 0);
        check({tag, "_busy1"}, busy1, 0);     check({tag, "_done1"}, done1, 0);
        check({tag, "_pass1"}, pass1, 0);     check({tag, "_abort1"}, abort1, 0);
        check({tag, "_err1"}, err1, 0);
        check({tag, "_rd_en2"}, rd_en2, 0);   check({tag, "_rd_addr2"}, rd_addr2, 0);
        check({tag, "_busy2"}, busy2, 0);     check({tag, "_done2"}, done2, 0);
        check({tag, "_pass2"}, pass2, 0);     check({tag, "_abort2"}, abort2, 0);
        check({tag, "_err2"}, err2, 0);
    endtask

    task automatic run_scan(input string tag);
        int n, lat1, lat2, a1, a2, e1, e2;
        e1 = ref_errs(16);
        e2 = ref_errs(32);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_start_done_clr"}, done1, 0);
        check({tag, "_start_err_clr"}, err1, 0);
        n = 1; lat1 = 0; lat2 = 0; a1 = 0; a2 = 0;
        while ((lat1 == 0 || lat2 == 0) && n < 100) begin
            if (done1 && lat1 == 0) lat1 = n;
            if (done2 && lat2 == 0) lat2 = n;
            check({tag, "_busy1"}, busy1, !done1);
            check({tag, "_busy2"}, busy2, !done2);
            if (rd_en1) begin check({tag, "_addr_seq1"}, rd_addr1, a1); a1++; end
            else check({tag, "_idle_addr1"}, rd_addr1, 0);
            if (rd_en2) begin check({tag, "_addr_seq2"}, rd_addr2, a2); a2++; end
            else check({tag, "_idle_addr2"}, rd_addr2, 0);
            if (lat1 == 0 || lat2 == 0) begin tick(); n++; end
        end
        check({tag, "_latency1"}, lat1, 16 + 1 + 1);
        check({tag, "_latency2"}, lat2, 32 + 3 + 1);
        check({tag, "_nreads1"}, a1, 16);
        check({tag, "_nreads2"}, a2, 32);
        check({tag, "_err1"}, err1, e1);
        check({tag, "_err2"}, err2, e2);
        check({tag, "_pass1"}, pass1, (e1 == 0));
        check({tag, "_pass2"}, pass2, (e2 == 0));
`ifdef BRAM_CHK_FIRST_ERR_CAPTURE_EN
        check({tag, "_fe_vld1"}, fe_vld1, (e1 != 0));
        check({tag, "_fe_addr1"}, fe_addr1, (e1 != 0) ? ref_first(16) : 0);
        check({tag, "_fe_data1"}, fe_data1, (e1 != 0) ? mem[ref_first(16)] : 0);
        check({tag, "_fe_vld2"}, fe_vld2, (e2 != 0));
        check({tag, "_fe_addr2"}, fe_addr2, (e2 != 0) ? ref_first(32) : 0);
        check({tag, "_fe_data2"}, fe_data2, (e2 != 0) ? mem[ref_first(32)] : 0);
`endif
    endtask

    task automatic run_to_addr(input int target);
        int k = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (rd_addr1 !== 4'(target) && k < 50) begin tick(); k++; end
        check("reach_addr", rd_addr1, target);
    endtask

    initial begin
        fill_mem(0);
        // Reset, including priority over a simultaneous start
        tick();
        start = 1'b1;
        tick();
        check_idle("reset");
        reset = 1'b0;
        start = 1'b0;
        tick();
        check_idle("post_reset");

        // Clean memory
        run_scan("clean");

        // Single corrupt word at address 5
        mem[5] = 32'hDEAD;
        run_scan("addr5");

        // Corrupt first and last words of each depth
        fill_mem(0);
        mem[0] = 32'h1234_5678; mem[15] = 32'hFFFF_0000; mem[31] = 32'h0;
        run_scan("ends");

        // Every word zero: only address 0 matches
        for (int a = 0; a < 32; a++) mem[a] = 32'h0;
        run_scan("zeros");

        // Randomized corruption patterns, restarted from DONE
        for (int r = 0; r < 4; r++) begin
            fill_mem(25);
            run_scan("rand");
        end

        // Lock loss at address 7 with address 2 corrupt
        fill_mem(0);
        mem[2] = 32'hBAD0;
        run_to_addr(7);
        locked = 1'b0;
        tick();
        check("abort_pulse1", abort1, 1);  check("abort_pulse2", abort2, 1);
        check("abort_busy1", busy1, 0);    check("abort_busy2", busy2, 0);
        check("abort_done1", done1, 0);    check("abort_done2", done2, 0);
        check("abort_rd_en1", rd_en1, 0);
        check("abort_err1", err1, 1);      check("abort_err2", err2, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_once1", abort1, 0);   check("abort_once2", abort2, 0);
        check("unlocked_start_busy1", busy1, 0);
        check("unlocked_start_busy2", busy2, 0);
        check("unlocked_err_hold1", err1, 1);
        locked = 1'b1;
        tick();
        check("unlocked_start_idle", rd_en1, 0);

        // Reset together with start at address 9, then a full clean scan
        fill_mem(0);
        mem[1] = 32'h7;
        run_to_addr(9);
        check("pre_reset_err1", err1, 1);
        reset = 1'b1;
        start = 1'b1;
        tick();
        check_idle("midscan_reset");
        reset = 1'b0;
        start = 1'b0;
        tick();
        check_idle("after_midscan_reset");
        fill_mem(0);
        run_scan("post_reset_clean");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
